// File: rtl/uart_pkg.sv
// uart_pkg: shared UART FSM encoding, oversampling constants and default line settings
package uart_pkg;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;
  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 8;
  localparam int CLK_HZ_DEF = 100000000;
  localparam int BAUD_DEF = 9600;
endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: receive-side byte handshake and status flags toward the peripheral register file
interface uart_rx_if;
  logic [7:0] rx_data;
  logic rx_valid;
  logic rx_ack;
  logic overrun;
  logic frame_err;
  logic irq;
  modport master(output rx_data, rx_valid, overrun, frame_err, irq, input rx_ack);
  modport slave(input rx_data, rx_valid, overrun, frame_err, irq, output rx_ack);
endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running 0..DIV-1 counter pulsing tick once per oversample period
module uart_baud_tick #(
  parameter int DIV = 651
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);
  localparam int W = DIV > 1 ? $clog2(DIV) : 1;
  logic [W-1:0] cnt_q, cnt_d;
  assign tick = cnt_q == W'(DIV - 1);
  always_comb cnt_d = tick ? '0 : cnt_q + W'(1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled 8N1 receiver, 8E1 when UART_RX_PARITY_EN is defined, with valid/ack delivery
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ = CLK_HZ_DEF,
  parameter int BAUD = BAUD_DEF,
  parameter int DIV = CLK_HZ / (BAUD * OVERSAMPLE)
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  uart_rx_if.master rx
);
`ifdef UART_RX_PARITY_EN
  localparam rx_state_e AFTER_DATA = RX_PARITY;
`else
  localparam rx_state_e AFTER_DATA = RX_STOP;
`endif
  rx_state_e state_q, state_d;
  logic [1:0] sync_q, sync_d;
  logic [3:0] sc_q, sc_d;
  logic [2:0] bi_q, bi_d;
  logic [7:0] shift_q, shift_d, data_q, data_d;
  logic par_err_q, par_err_d, valid_q, valid_d, overrun_q, overrun_d, ferr_q, ferr_d;
  logic tick, din_s, mid, full, stop_hit, good, deliver, take;
  uart_baud_tick #(.DIV(DIV)) u_tick (.clk(clk), .reset(reset), .tick(tick));
  assign din_s = sync_q[1];
  assign mid = sc_q == 4'(MID_SAMPLE - 1);
  assign full = sc_q == 4'(OVERSAMPLE - 1);
  always_comb begin
    sync_d = {sync_q[0], din};
    state_d = state_q;
    sc_d = tick ? sc_q + 4'd1 : sc_q;
    bi_d = bi_q;
    shift_d = shift_q;
    par_err_d = par_err_q;
    stop_hit = 1'b0;
    if (tick)
      case (state_q)
        RX_IDLE: begin
          sc_d = '0;
          state_d = din_s ? RX_IDLE : RX_START;
        end
        RX_START:
          if (mid) begin
            sc_d = '0;
            bi_d = '0;
            state_d = din_s ? RX_IDLE : RX_DATA;
          end
        RX_DATA:
          if (full) begin
            shift_d[bi_q] = din_s;
            bi_d = bi_q + 3'd1;
            state_d = bi_q == 3'd7 ? AFTER_DATA : RX_DATA;
          end
`ifdef UART_RX_PARITY_EN
        RX_PARITY:
          if (full) begin
            par_err_d = ^{shift_q, din_s};
            state_d = RX_STOP;
          end
`endif
        RX_STOP:
          if (full) begin
            stop_hit = 1'b1;
            state_d = RX_IDLE;
          end
        default: state_d = RX_IDLE;
      endcase
  end
  assign good = din_s & ~par_err_q;
  assign deliver = stop_hit & good;
  assign take = deliver & (~valid_q | rx.rx_ack);
  always_comb begin
    data_d = take ? shift_q : data_q;
    valid_d = take | (valid_q & ~rx.rx_ack);
    overrun_d = (deliver & valid_q & ~rx.rx_ack) | (overrun_q & ~rx.rx_ack);
    ferr_d = (stop_hit & ~good) | (ferr_q & ~rx.rx_ack);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= RX_IDLE;
      sync_q <= 2'b11;
      sc_q <= '0;
      bi_q <= '0;
      shift_q <= '0;
      par_err_q <= 1'b0;
      data_q <= '0;
      valid_q <= 1'b0;
      overrun_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q <= sync_d;
      sc_q <= sc_d;
      bi_q <= bi_d;
      shift_q <= shift_d;
      par_err_q <= par_err_d;
      data_q <= data_d;
      valid_q <= valid_d;
      overrun_q <= overrun_d;
      ferr_q <= ferr_d;
    end
  assign rx.rx_data = data_q;
  assign rx.rx_valid = valid_q;
  assign rx.overrun = overrun_q;
  assign rx.frame_err = ferr_q;
  assign rx.irq = valid_q | overrun_q | ferr_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed table-driven bench for uart_rx at 16 clk per bit, parity-aware via UART_RX_PARITY_EN
module tb_uart_rx;
  import uart_pkg::*;
  typedef struct {
    logic [7:0] b;
    logic stop;
    logic ack;
    logic [7:0] ed;
    logic ev, eo, ef;
  } vec_t;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic din = 1'b1;
  int tests = 0;
  int fails = 0;
  vec_t tbl[6];
  uart_rx_if rx();
  uart_rx #(.CLK_HZ(1600000), .BAUD(100000)) dut (.clk(clk), .reset(reset), .din(din), .rx(rx));
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic check_out(input string tag, input logic [7:0] d, input logic v, input logic o, input logic f);
    check({tag, ".rx_data"}, 32'(rx.rx_data), 32'(d));
    check({tag, ".rx_valid"}, 32'(rx.rx_valid), 32'(v));
    check({tag, ".overrun"}, 32'(rx.overrun), 32'(o));
    check({tag, ".frame_err"}, 32'(rx.frame_err), 32'(f));
    check({tag, ".irq"}, 32'(rx.irq), 32'(v | o | f));
  endtask
  task automatic send_frame(input logic [7:0] b, input logic stop, input logic pflip);
    @(posedge clk);
    din = 1'b0;
    repeat (16) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      din = b[i];
      repeat (16) @(posedge clk);
    end
`ifdef UART_RX_PARITY_EN
    din = ^b ^ pflip;
    repeat (16) @(posedge clk);
`endif
    din = stop;
    repeat (16) @(posedge clk);
    din = 1'b1;
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic pulse_ack();
    @(posedge clk);
    rx.rx_ack = 1'b1;
    @(posedge clk);
    rx.rx_ack = 1'b0;
    #1;
  endtask
  initial begin
    int n;
    rx.rx_ack = 1'b0;
    tbl[0] = '{8'h3C, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1};
    tbl[1] = '{8'h11, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{8'h22, 1'b1, 1'b1, 8'h11, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{8'hC3, 1'b1, 1'b0, 8'hC3, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{8'h00, 1'b1, 1'b1, 8'hC3, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{8'hFF, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b1};
    idle(3);
    check_out("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    idle(5);
    n = 0;
    fork
      send_frame(8'hA5, 1'b1, 1'b0);
      begin
        @(posedge clk);
        for (int i = 1; i <= 250; i++) begin
          @(posedge clk);
          #1;
          if (rx.rx_valid) begin
            n = i;
            break;
          end
        end
      end
    join
    check("a5_latency_window", 32'(n >= 16 * NB - 10 && n <= 16 * NB), 32'd1);
    idle(20);
    check_out("a5", 8'hA5, 1'b1, 1'b0, 1'b0);
    pulse_ack();
    check_out("a5_ack", 8'hA5, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    din = 1'b0;
    repeat (4) @(posedge clk);
    din = 1'b1;
    idle(40);
    check_out("glitch", 8'hA5, 1'b0, 1'b0, 1'b0);
    check("glitch_idle", 32'(dut.state_q), 32'(RX_IDLE));
    for (int k = 0; k < 6; k++) begin
      send_frame(tbl[k].b, tbl[k].stop, 1'b0);
      idle(20);
      check_out($sformatf("vec%0d", k), tbl[k].ed, tbl[k].ev, tbl[k].eo, tbl[k].ef);
      if (tbl[k].ack) begin
        pulse_ack();
        check_out($sformatf("vec%0d_ack", k), tbl[k].ed, 1'b0, 1'b0, 1'b0);
      end
    end
    send_frame(8'h11, 1'b1, 1'b0);
    idle(20);
    check_out("pre_coinc", 8'h11, 1'b1, 1'b0, 1'b0);
    fork
      send_frame(8'h22, 1'b1, 1'b0);
      begin
        @(posedge clk);
        repeat (16 * NB - 6) @(posedge clk);
        rx.rx_ack = 1'b1;
        @(posedge clk);
        rx.rx_ack = 1'b0;
      end
    join
    idle(20);
    check_out("coinc_ack", 8'h22, 1'b1, 1'b0, 1'b0);
    fork
      send_frame(8'hFF, 1'b1, 1'b0);
      begin
        @(posedge clk);
        repeat (72) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_out("mid_reset", 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        reset = 1'b1;
      end
    join
    idle(40);
    check_out("post_reset", 8'h00, 1'b0, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b1, 1'b0);
    idle(20);
    check_out("5a", 8'h5A, 1'b1, 1'b0, 1'b0);
    pulse_ack();
`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0);
    idle(20);
    check_out("par_good", 8'h07, 1'b1, 1'b0, 1'b0);
    pulse_ack();
    send_frame(8'h07, 1'b1, 1'b1);
    idle(20);
    check_out("par_bad", 8'h07, 1'b0, 1'b0, 1'b1);
    pulse_ack();
    check_out("par_bad_ack", 8'h07, 1'b0, 1'b0, 1'b0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
